// File: rtl/fifo_word_serializer.sv
// Drains DATA_WIDTH-bit words from a FIFO read port and emits them as OUT_WIDTH-bit
// beats on a valid/ready stream, with a one-word prefetch buffer to hide read latency.
module fifo_word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic [15:0]           words_sent,
  output logic                  busy
);

  localparam int NBEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int IDXW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBEATS - 1);

  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] nxt_q, nxt_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  cur_valid_q, cur_valid_d;
  logic                  nxt_valid_q, nxt_valid_d;
  logic                  pend_q, pend_d;
  logic [15:0]           words_q, words_d;

  logic [1:0]            occupancy;
  logic                  beat_fire;
  logic                  last_fire;
  logic [IDXW-1:0]       sel;
  logic [OUT_WIDTH-1:0]  beat;

  always_comb begin
    occupancy  = {1'b0, cur_valid_q} + {1'b0, nxt_valid_q} + {1'b0, pend_q};
    fifo_rd_en = !reset && !fifo_empty && (occupancy < 2'd2);
    beat_fire  = cur_valid_q && out_ready;
    last_fire  = beat_fire && (idx_q == LAST_IDX);
  end

  // Beat mux: the stored word stays intact and the index picks the slice to present.
  always_comb begin
    sel  = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
    beat = '0;
    for (int k = 0; k < NBEATS; k++) begin
      if (sel == IDXW'(k)) beat = cur_q[k*OUT_WIDTH +: OUT_WIDTH];
    end
    out_valid  = cur_valid_q;
    out_data   = cur_valid_q ? beat : '0;
    out_last   = cur_valid_q && (idx_q == LAST_IDX);
    words_sent = words_q;
    busy       = (occupancy != 2'd0);
  end

  always_comb begin
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    idx_d       = idx_q;
    cur_valid_d = cur_valid_q;
    nxt_valid_d = nxt_valid_q;
    words_d     = words_q;
    pend_d      = fifo_rd_en;

    if (beat_fire) begin
      if (last_fire) begin
        words_d = words_q + 16'd1;
        idx_d   = '0;
        if (nxt_valid_q) begin
          cur_d       = nxt_q;
          cur_valid_d = 1'b1;
          nxt_valid_d = 1'b0;
        end else begin
          cur_valid_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + IDXW'(1);
      end
    end

    // Returning data refills cur only when nothing else is queued ahead of it.
    if (pend_q) begin
      if (!cur_valid_q || (last_fire && !nxt_valid_q)) begin
        cur_d       = fifo_rd_data;
        cur_valid_d = 1'b1;
        idx_d       = '0;
      end else begin
        nxt_d       = fifo_rd_data;
        nxt_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q       <= '0;
      nxt_q       <= '0;
      idx_q       <= '0;
      cur_valid_q <= 1'b0;
      nxt_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      idx_q       <= idx_d;
      cur_valid_q <= cur_valid_d;
      nxt_valid_q <= nxt_valid_d;
      pend_q      <= pend_d;
      words_q     <= words_d;
    end
  end

endmodule
